// File: rtl/pma_region_checker.sv
// Runtime-programmable physical memory attribute checker: NrRules address
// regions, each of NrPorts channels with a one-deep registered lookup pipeline.
module pma_region_checker #(
  parameter int unsigned NrRules   = 8,
  parameter int unsigned NrPorts   = 2,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned CntWidth  = 32,
  localparam int unsigned IdxW     = (NrRules > 1) ? $clog2(NrRules) : 1,
  localparam int unsigned CfgIdxW  = $clog2(NrRules) + 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cfg_valid_i,
  output logic                           cfg_ready_o,
  input  logic [CfgIdxW-1:0]             cfg_idx_i,
  input  logic [AddrWidth-1:0]           cfg_base_i,
  input  logic [AddrWidth-1:0]           cfg_len_i,
  input  logic [3:0]                     cfg_attr_i,
  output logic                           cfg_err_o,
  input  logic [NrPorts-1:0]             req_valid_i,
  output logic [NrPorts-1:0]             req_ready_o,
  input  logic [NrPorts*AddrWidth-1:0]   req_addr_i,
  output logic [NrPorts-1:0]             rsp_valid_o,
  input  logic [NrPorts-1:0]             rsp_ready_i,
  output logic [NrPorts*3-1:0]           rsp_attr_o,
  output logic [NrPorts-1:0]             rsp_hit_o,
  output logic [NrPorts*IdxW-1:0]        rsp_idx_o,
  output logic [NrPorts*CntWidth-1:0]    miss_cnt_o
);

  typedef enum logic {EMPTY, FULL} port_state_e;

  // The limit is one bit wider than an address so a region ending exactly at
  // (or past) the top of the address space never wraps to low addresses.
  function automatic logic rule_match(input logic [AddrWidth-1:0] base,
                                      input logic [AddrWidth-1:0] len,
                                      input logic [AddrWidth-1:0] addr);
    logic [AddrWidth:0] lim;
    lim = {1'b0, base} + {1'b0, len};
    return (len != '0) && (addr >= base) && ({1'b0, addr} < lim);
  endfunction

  logic [NrRules-1:0][AddrWidth-1:0] base_q, base_d, len_q, len_d;
  logic [NrRules-1:0][3:0]           attr_q, attr_d;
  logic [NrRules-1:0]                wr_sel;
  logic                              cfg_err_q, cfg_err_d;

  port_state_e [NrPorts-1:0]         state_q, state_d;
  logic [NrPorts-1:0]                rsp_hit_q, rsp_hit_d;
  logic [NrPorts-1:0][2:0]           rsp_attr_q, rsp_attr_d;
  logic [NrPorts-1:0][IdxW-1:0]      rsp_idx_q, rsp_idx_d;
  logic [NrPorts-1:0][CntWidth-1:0]  miss_cnt_q, miss_cnt_d;

  logic [NrPorts-1:0]                lk_hit;
  logic [NrPorts-1:0][2:0]           lk_attr;
  logic [NrPorts-1:0][IdxW-1:0]      lk_idx;

  assign cfg_ready_o = !rst_i;

  // Out-of-range and locked targets simply select no entry, which is the error case.
  always_comb begin : cfg_comb
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    base_d = base_q;
    len_d  = len_q;
    attr_d = attr_q;
    wr_sel = '0;
    for (int r = 0; r < NrRules; r++) begin
      wr_sel[r] = cfg_valid_i && cfg_ready_o && (cfg_idx_i == CfgIdxW'(r)) && !attr_q[r][3];
      if (wr_sel[r]) begin
        base_d[r] = cfg_base_i;
        len_d[r]  = cfg_len_i;
        attr_d[r] = cfg_attr_i;
      end
    end
    cfg_err_d = cfg_valid_i && cfg_ready_o && (wr_sel == '0);
  end

  // Scan from the top so the lowest-index matching rule is the last to win.
  always_comb begin : lookup_comb
    lk_hit  = '0;
    lk_attr = '0;
    lk_idx  = '0;
    for (int p = 0; p < NrPorts; p++) begin
      for (int r = NrRules - 1; r >= 0; r--) begin
        if (rule_match(base_q[r], len_q[r], req_addr_i[p*AddrWidth +: AddrWidth])) begin
          lk_hit[p]  = 1'b1;
          lk_attr[p] = attr_q[r][2:0];
          lk_idx[p]  = IdxW'(r);
        end
      end
    end
  end

  always_comb begin : port_comb
    state_d     = state_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_attr_d  = rsp_attr_q;
    rsp_idx_d   = rsp_idx_q;
    miss_cnt_d  = miss_cnt_q;
    rsp_valid_o = '0;
    req_ready_o = '0;
    for (int p = 0; p < NrPorts; p++) begin
      rsp_valid_o[p] = (state_q[p] == FULL);
      req_ready_o[p] = (state_q[p] == EMPTY) || rsp_ready_i[p];
      if (rsp_valid_o[p] && rsp_ready_i[p] && !rsp_hit_q[p] && (miss_cnt_q[p] != '1))
        miss_cnt_d[p] = miss_cnt_q[p] + CntWidth'(1);
      if (req_valid_i[p] && req_ready_o[p]) begin
        state_d[p]    = FULL;
        rsp_hit_d[p]  = lk_hit[p];
        rsp_attr_d[p] = lk_attr[p];
        rsp_idx_d[p]  = lk_idx[p];
      end else if (rsp_valid_o[p] && rsp_ready_i[p]) begin
        state_d[p] = EMPTY;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the rule table is reset as well, since reset must clear every region (it is a register file, not a RAM).
      base_q     <= '0;
      len_q      <= '0;
      attr_q     <= '0;
      cfg_err_q  <= 1'b0;
      rsp_hit_q  <= '0;
      rsp_attr_q <= '0;
      rsp_idx_q  <= '0;
      miss_cnt_q <= '0;
      for (int p = 0; p < NrPorts; p++) state_q[p] <= EMPTY;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge _d values.
      base_q     <= base_d;
      len_q      <= len_d;
      attr_q     <= attr_d;
      cfg_err_q  <= cfg_err_d;
      rsp_hit_q  <= rsp_hit_d;
      rsp_attr_q <= rsp_attr_d;
      rsp_idx_q  <= rsp_idx_d;
      miss_cnt_q <= miss_cnt_d;
      state_q    <= state_d;
    end
  end

  assign cfg_err_o  = cfg_err_q;
  assign rsp_hit_o  = rsp_hit_q;
  assign rsp_attr_o = rsp_attr_q;
  assign rsp_idx_o  = rsp_idx_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_pma_region_checker.sv
// Self-checking bench for pma_region_checker: a region-list/scoreboard model
// checked every cycle, plus directed lookups with hand-computed results.
module tb_pma_region_checker;

  localparam int NR = 8;
  localparam int NP = 2;
  localparam int AW = 64;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [3:0]     cfg_idx = '0;
  logic [AW-1:0]  cfg_base = '0;
  logic [AW-1:0]  cfg_len = '0;
  logic [3:0]     cfg_attr = '0;
  logic           cfg_err;
  logic [NP-1:0]  req_valid = '0;
  logic [NP-1:0]  req_ready;
  logic [NP*AW-1:0] req_addr = '0;
  logic [NP-1:0]  rsp_valid;
  logic [NP-1:0]  rsp_ready = '1;
  logic [NP*3-1:0] rsp_attr;
  logic [NP-1:0]  rsp_hit;
  logic [NP*3-1:0] rsp_idx;
  logic [NP*CW-1:0] miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pma_region_checker #(.NrRules(NR), .NrPorts(NP), .AddrWidth(AW), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_idx_i(cfg_idx),
    .cfg_base_i(cfg_base), .cfg_len_i(cfg_len), .cfg_attr_i(cfg_attr), .cfg_err_o(cfg_err),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_attr_o(rsp_attr),
    .rsp_hit_o(rsp_hit), .rsp_idx_o(rsp_idx), .miss_cnt_o(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       hit;
    logic [2:0] attr;
    logic [2:0] idx;
  } rsp_t;

  logic [AW-1:0] m_base [NR];
  logic [AW-1:0] m_len  [NR];
  logic [3:0]    m_attr [NR];
  rsp_t          m_q [NP][$];
  int            m_cnt [NP];
  logic          m_err;

  // First rule in list order whose [base, base+len) contains the address.
  function automatic rsp_t model_lookup(input logic [AW-1:0] a);
    rsp_t r;
    r = '0;
    for (int i = 0; i < NR; i++) begin
      if (m_len[i] != 0 && a >= m_base[i] && (a - m_base[i]) < m_len[i]) begin
        r.hit  = 1'b1;
        r.attr = m_attr[i][2:0];
        r.idx  = 3'(i);
        return r;
      end
    end
    return r;
  endfunction

  // Compare on the falling edge, then advance the model with the inputs the
  // next rising edge will sample.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_base[i] = '0; m_len[i] = '0; m_attr[i] = '0;
      end
      for (int p = 0; p < NP; p++) begin
        m_q[p].delete();
        m_cnt[p] = 0;
      end
      m_err = 1'b0;
    end

    check("cfg_ready", cfg_ready, !rst);
    check("cfg_err", cfg_err, m_err);
    for (int p = 0; p < NP; p++) begin
      check($sformatf("p%0d_rsp_valid", p), rsp_valid[p], m_q[p].size() != 0);
      check($sformatf("p%0d_req_ready", p), req_ready[p], m_q[p].size() == 0 || rsp_ready[p]);
      check($sformatf("p%0d_miss_cnt", p), miss_cnt[p*CW +: CW], m_cnt[p]);
      if (m_q[p].size() != 0 && rsp_valid[p]) begin
        check($sformatf("p%0d_rsp_hit", p), rsp_hit[p], m_q[p][0].hit);
        check($sformatf("p%0d_rsp_attr", p), rsp_attr[p*3 +: 3], m_q[p][0].attr);
        check($sformatf("p%0d_rsp_idx", p), rsp_idx[p*3 +: 3], m_q[p][0].idx);
      end
      if (rst) check($sformatf("p%0d_rsp_reset", p), {rsp_hit[p], rsp_attr[p*3 +: 3], rsp_idx[p*3 +: 3]}, 0);
    end

    if (!rst) begin
      for (int p = 0; p < NP; p++) begin
        logic full, fire, acc;
        full = m_q[p].size() != 0;
        fire = full && rsp_ready[p];
        acc  = req_valid[p] && (!full || rsp_ready[p]);
        if (fire) begin
          if (!m_q[p][0].hit && m_cnt[p] < CNT_MAX) m_cnt[p]++;
          void'(m_q[p].pop_front());
        end
        if (acc) m_q[p].push_back(model_lookup(req_addr[p*AW +: AW]));
      end
      m_err = 1'b0;
      if (cfg_valid) begin
        if (cfg_idx < NR && !m_attr[cfg_idx][3]) begin
          m_base[cfg_idx] = cfg_base;
          m_len[cfg_idx]  = cfg_len;
          m_attr[cfg_idx] = cfg_attr;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cfg_write(input logic [3:0] idx, input logic [AW-1:0] base,
                           input logic [AW-1:0] len, input logic [3:0] attr, input logic exp_err);
    cfg_valid = 1'b1; cfg_idx = idx; cfg_base = base; cfg_len = len; cfg_attr = attr;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check($sformatf("cfg_err_pulse_idx%0d", idx), cfg_err, exp_err);
    @(posedge clk); #1;
    check($sformatf("cfg_err_clear_idx%0d", idx), cfg_err, 1'b0);
  endtask

  task automatic lookup0(input logic [AW-1:0] a, input logic eh, input logic [2:0] ea, input logic [2:0] ei);
    req_valid[0] = 1'b1; req_addr[AW-1:0] = a;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check($sformatf("lookup_%h", a), {rsp_valid[0], rsp_hit[0], rsp_attr[2:0], rsp_idx[2:0]},
          {1'b1, eh, ea, ei});
  endtask

  logic [AW-1:0] tbl0 [4] = '{64'h8000_0000, 64'h1_8000, 64'h2000_0000, 64'hC000_0000};
  logic [AW-1:0] tbl1 [4] = '{64'h3000_0000, 64'hF000_0000, 64'h1000, 64'h9000_0000};

  initial begin
    int   k1;
    logic acc1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_miss_cnt0", miss_cnt[CW-1:0], 0);

    // Miss on an empty table.
    lookup0(64'h8000_1000, 1'b0, 3'b000, 3'd0);
    @(posedge clk); #1;
    check("miss_cnt0_after_first", miss_cnt[CW-1:0], 1);

    // Single region, both boundaries.
    cfg_write(4'd0, 64'h8000_0000, 64'h4000_0000, 4'b0111, 1'b0);
    lookup0(64'h8000_0000, 1'b1, 3'b111, 3'd0);
    lookup0(64'hBFFF_FFFF, 1'b1, 3'b111, 3'd0);
    lookup0(64'hC000_0000, 1'b0, 3'b000, 3'd0);

    // Overlap priority, then disable the winner.
    cfg_write(4'd2, 64'h0, 64'h10_0000, 4'b0010, 1'b0);
    cfg_write(4'd1, 64'h1_0000, 64'h1_0000, 4'b0100, 1'b0);
    lookup0(64'h1_8000, 1'b1, 3'b100, 3'd1);
    cfg_write(4'd1, 64'h1_0000, 64'h0, 4'b0100, 1'b0);
    lookup0(64'h1_8000, 1'b1, 3'b010, 3'd2);

    // Locked entry and out-of-range index are rejected.
    cfg_write(4'd3, 64'h2000_0000, 64'h1000, 4'b1011, 1'b0);
    cfg_write(4'd3, 64'h2000_0000, 64'h1000, 4'b0100, 1'b1);
    lookup0(64'h2000_0800, 1'b1, 3'b011, 3'd3);
    cfg_write(4'd8, 64'h2000_0000, 64'h1000, 4'b0100, 1'b1);
    lookup0(64'h2000_0800, 1'b1, 3'b011, 3'd3);

    // Config write and lookup in the same cycle: lookup sees the old table.
    cfg_valid = 1'b1; cfg_idx = 4'd4; cfg_base = 64'h3000_0000; cfg_len = 64'h100; cfg_attr = 4'b0110;
    req_valid[0] = 1'b1; req_addr[AW-1:0] = 64'h3000_0010;
    @(posedge clk); #1;
    cfg_valid = 1'b0; req_valid[0] = 1'b0;
    check("same_cycle_old_attr", {rsp_valid[0], rsp_hit[0], rsp_attr[2:0], rsp_idx[2:0]}, {1'b1, 1'b0, 3'b000, 3'd0});
    lookup0(64'h3000_0010, 1'b1, 3'b110, 3'd4);

    // Both ports streaming, port 1 back-pressured for three cycles.
    k1 = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 2'b11;
      req_addr[AW-1:0]    = tbl0[i % 4];
      req_addr[2*AW-1:AW] = tbl1[k1 % 4];
      rsp_ready[1] = (i >= 2 && i <= 4) ? 1'b0 : 1'b1;
      @(negedge clk);
      check("p0_stream_ready", req_ready[0], 1'b1);
      if (i >= 2 && i <= 4) check("p1_stall_ready", req_ready[1], 1'b0);
      acc1 = req_ready[1];
      @(posedge clk); #1;
      if (acc1) k1++;
    end
    req_valid = '0; rsp_ready = '1;
    check("p1_stream_accepts", k1, 7);
    repeat (2) @(posedge clk); #1;

    // Port 1 miss counter saturates at 2^CW-1.
    req_valid[1] = 1'b1; req_addr[2*AW-1:AW] = 64'hF000_0000;
    repeat (20) @(posedge clk); #1;
    req_valid[1] = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("p1_miss_saturated", miss_cnt[2*CW-1:CW], CNT_MAX);

    // Asynchronous reset while a response is held.
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1; req_addr[AW-1:0] = 64'h8000_0000;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("held_rsp_before_reset", rsp_valid[0], 1'b1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_rsp_valid", rsp_valid[0], 1'b0);
    check("async_rst_cfg_ready", cfg_ready, 1'b0);
    check("async_rst_miss_cnt0", miss_cnt[CW-1:0], 0);
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = '1;

    // Lock cleared by reset; table empty again.
    lookup0(64'h2000_0800, 1'b0, 3'b000, 3'd0);
    cfg_write(4'd3, 64'h2000_0000, 64'h1000, 4'b0001, 1'b0);
    lookup0(64'h2000_0800, 1'b1, 3'b001, 3'd3);

    // Top-of-address-space regions never wrap.
    cfg_write(4'd0, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 4'b0001, 1'b0);
    lookup0(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'b001, 3'd0);
    lookup0(64'h0, 1'b0, 3'b000, 3'd0);
    lookup0(64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 3'b000, 3'd0);
    cfg_write(4'd1, 64'hFFFF_FFFF_FFFF_F800, 64'h1000, 4'b0010, 1'b0);
    lookup0(64'h100, 1'b0, 3'b000, 3'd0);
    lookup0(64'hFFFF_FFFF_FFFF_F900, 1'b1, 3'b001, 3'd0);

    repeat (3) @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
